// File: rtl/chip_prog_receiver.sv
// Serial programming receiver: oversamples FPGA sclk/sdin on i_mainclk and loads A1/A2 gain codes.
// Optional mid-frame idle timeout with abort pulse is enabled by defining PROG_TIMEOUT_EN.
module chip_prog_receiver #(
  parameter int NBITS      = 5,
  parameter int GAINA1_RST = 0,
  parameter int GAINA2_RST = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic       i_mainclk,
  input  logic       i_resetAll,
  input  logic       i_sclk,
  input  logic       i_sdin,
  output logic [2:0] o_gainA1,
  output logic [1:0] o_gainA2,
  output logic       o_ready,
  output logic       o_abort
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {sWAIT, sSHIFT, sDONE} state_e;

  state_e           state_q, state_d;
  logic             sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic             sdin_s1_q, sdin_s2_q;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [2:0]       gain_a1_q, gain_a1_d;
  logic [1:0]       gain_a2_q, gain_a2_d;
  logic             ready_q, ready_d;
  logic             sclk_rise;
  logic [NBITS-1:0] shift_val;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign shift_val = {shreg_q[NBITS-2:0], sdin_s2_q};

`ifdef PROG_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          abort_q, abort_d;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    gain_a1_d = gain_a1_q;
    gain_a2_d = gain_a2_q;
    ready_d   = ready_q;
`ifdef PROG_TIMEOUT_EN
    idle_d    = '0;
    abort_d   = 1'b0;
`endif
    case (state_q)
      sWAIT: begin
        if (sclk_rise) begin
          shreg_d  = shift_val;
          bitcnt_d = CW'(1);
          state_d  = sSHIFT;
        end
      end
      sSHIFT: begin
        if (bitcnt_q == CW'(NBITS)) begin
          state_d   = sDONE;
          gain_a1_d = shreg_q[NBITS-1 -: 3];
          gain_a2_d = shreg_q[1:0];
          ready_d   = 1'b1;
        end else if (sclk_rise) begin
          shreg_d  = shift_val;
          bitcnt_d = bitcnt_q + CW'(1);
        end
`ifdef PROG_TIMEOUT_EN
        // Abort on the edge where the idle count would reach TIMEOUT.
        else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d  = sWAIT;
          shreg_d  = '0;
          bitcnt_d = '0;
          abort_d  = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
`endif
      end
      sDONE:   ;
      default: state_d = sWAIT;
    endcase
  end

  always_ff @(posedge i_mainclk) begin
    if (i_resetAll) begin
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      sdin_s1_q   <= 1'b1;
      sdin_s2_q   <= 1'b1;
      state_q     <= sWAIT;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      gain_a1_q   <= 3'(GAINA1_RST);
      gain_a2_q   <= 2'(GAINA2_RST);
      ready_q     <= 1'b0;
    end else begin
      sclk_s1_q   <= i_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdin_s1_q   <= i_sdin;
      sdin_s2_q   <= sdin_s1_q;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      gain_a1_q   <= gain_a1_d;
      gain_a2_q   <= gain_a2_d;
      ready_q     <= ready_d;
    end
  end

`ifdef PROG_TIMEOUT_EN
  always_ff @(posedge i_mainclk) begin
    if (i_resetAll) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= abort_d;
    end
  end
  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

  assign o_gainA1 = gain_a1_q;
  assign o_gainA2 = gain_a2_q;
  assign o_ready  = ready_q;

endmodule

// File: tb/tb_chip_prog_receiver.sv
// Scoreboard bench for chip_prog_receiver: a frame-level model queues expected ready/abort events,
// an independent monitor pops and checks them as the DUT raises o_ready / o_abort.
module tb_chip_prog_receiver;
  localparam int G1R = 0;
  localparam int G2R = 0;

  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b1, sdin = 1'b0;
  logic [2:0] o_gainA1;
  logic [1:0] o_gainA2;
  logic       o_ready, o_abort;

  chip_prog_receiver dut (
    .i_mainclk (clk),
    .i_resetAll(rst),
    .i_sclk    (sclk),
    .i_sdin    (sdin),
    .o_gainA1  (o_gainA1),
    .o_gainA2  (o_gainA2),
    .o_ready   (o_ready),
    .o_abort   (o_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] g1;
    logic [1:0] g2;
    int         due;
  } rdy_ev_t;

  rdy_ev_t rq[$];
  int      aq[$];
  int      total = 0;
  int      bad = 0;

  // Frame-level reference: bits seen since reset/abort, and the committed gains.
  int         m_cnt;
  bit         m_done;
  logic [4:0] m_sh;
  logic [2:0] m_g1;
  logic [1:0] m_g2;
  int         last_rise;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_done = 0; m_sh = '0; m_g1 = 3'(G1R); m_g2 = 2'(G2R);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_clear();
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_rdy"}, int'(o_ready), int'(m_done));
    chk({nm, "_g1"}, int'(o_gainA1), int'(m_g1));
    chk({nm, "_g2"}, int'(o_gainA2), int'(m_g2));
  endtask

  // One serial bit: sdin changes with sclk falling, raw rise after lo cycles, hold high hi cycles.
  task automatic send_bit(input bit b, input int lo, input int hi, input bit rst_on_detect = 1'b0);
    @(negedge clk); sclk = 1'b0; sdin = b;
    repeat (lo) @(negedge clk);
    sclk = 1'b1;
    if (rst_on_detect) begin
      // rise is detected two cycles on; reset lands on the capturing edge
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_clear();
    end else begin
      last_rise = cyc;
      if (!m_done) begin
        m_sh = {m_sh[3:0], b};
        m_cnt++;
        if (m_cnt == 5) begin
          m_done = 1;
          m_g1 = m_sh[4:2];
          m_g2 = m_sh[1:0];
          rq.push_back('{m_sh[4:2], m_sh[1:0], cyc + 4});
        end
      end
      repeat (hi) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [4:0] v, input int n, input int lo, input int hi);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], lo, hi);
  endtask

  // sclk held high for n cycles; an open partial frame times out when the option is built in.
  task automatic idle(input int n);
`ifdef PROG_TIMEOUT_EN
    if (m_cnt > 0 && !m_done && cyc + n >= last_rise + 258) begin
      aq.push_back(last_rise + 258);
      m_cnt = 0; m_sh = '0;
    end
`endif
    repeat (n) @(negedge clk);
  endtask

  initial begin : mon
    rdy_ev_t ev;
    bit      rp;
    rp = 1'b0;
    forever begin
      @(negedge clk);
      if (o_ready && !rp) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL ready_rise: unexpected at cyc %0d", cyc);
        end else begin
          ev = rq.pop_front();
          total++;
          if (o_gainA1 != ev.g1 || o_gainA2 != ev.g2 || cyc != ev.due) begin
            bad++;
            $display("FAIL ready_ev: got g1=%0d g2=%0d cyc=%0d want g1=%0d g2=%0d cyc=%0d",
                     o_gainA1, o_gainA2, cyc, ev.g1, ev.g2, ev.due);
          end
        end
      end
      rp = o_ready;
      if (o_abort) begin
        total++;
        if (aq.size() == 0) begin
          bad++;
          $display("FAIL abort: unexpected pulse at cyc %0d", cyc);
        end else if (aq[0] != cyc) begin
          bad++;
          $display("FAIL abort: pulse at cyc %0d want %0d", cyc, aq[0]);
          void'(aq.pop_front());
        end else begin
          void'(aq.pop_front());
        end
      end
    end
  end

  initial begin
    int lo, hi, nb;
    logic [4:0] v;
    model_clear();
    last_rise = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", int'(o_ready), 0);
    chk("reset_g1", int'(o_gainA1), G1R);
    chk("reset_g2", int'(o_gainA2), G2R);
    chk("reset_abort", int'(o_abort), 0);

    // Frame 6/1 at sclk period 32
    send_bits(5'b11001, 5, 16, 16);
    check_state("t1");
    chk("t1_g1c", int'(o_gainA1), 6);
    chk("t1_g2c", int'(o_gainA2), 1);

    // Sticky after done
    send_bits(5'b00000, 5, 16, 16);
    check_state("t2");
    chk("t2_g1c", int'(o_gainA1), 6);
    chk("t2_rdyc", int'(o_ready), 1);

    // Partial frame then reset, then full frame 3/2
    do_reset();
    send_bits(5'b00101, 3, 16, 16);
    check_state("t3_part");
    do_reset();
    send_bits(5'b00111, 4, 16, 16);
    check_state("t3_4bits");
    send_bit(1'b0, 16, 16);
    check_state("t3");
    chk("t3_g1c", int'(o_gainA1), 3);
    chk("t3_g2c", int'(o_gainA2), 2);

    // sdin toggling with sclk idle high
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); sdin = ~sdin;
    end
    idle(20);
    check_state("t4");
    chk("t4_rdyc", int'(o_ready), 0);

    // Two bits then a long stall, then frame 1,0,1,1,1
    do_reset();
    send_bits(5'b00001, 2, 16, 16);
    idle(300);
    send_bits(5'b10111, 5, 16, 16);
    idle(8);
    check_state("t5");
`ifdef PROG_TIMEOUT_EN
    chk("t5_g1c", int'(o_gainA1), 5);
    chk("t5_g2c", int'(o_gainA2), 3);
`endif

    // Reset on the same cycle as the 5th detected rise
    do_reset();
    send_bits(5'b01010, 4, 8, 8);
    send_bit(1'b1, 8, 8, 1'b1);
    idle(10);
    check_state("t6");
    chk("t6_rdyc", int'(o_ready), 0);

    // Randomized frames, partial frames and trailing pulses
    for (int it = 0; it < 25; it++) begin
      do_reset();
      lo = $urandom_range(3, 20);
      hi = $urandom_range(3, 20);
      v  = 5'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 5;
      send_bits(v, nb, lo, hi);
      idle(6);
      check_state("rnd");
      if (nb == 5) begin
        send_bits(5'($urandom), $urandom_range(0, 3), lo, hi);
        idle(6);
        check_state("rnd_post");
      end
    end

    idle(10);
    while (rq.size() > 0) begin
      total++; bad++;
      $display("FAIL ready_missing: due cyc %0d never seen", rq[0].due);
      void'(rq.pop_front());
    end
    while (aq.size() > 0) begin
      total++; bad++;
      $display("FAIL abort_missing: due cyc %0d never seen", aq[0]);
      void'(aq.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chip_prog_receiver.md
Name: chip_prog_receiver

Overview:
- On-chip serial programming receiver. It sits directly downstream of the FPGA programming source.
- Oversamples the serial clock and data lines from the FPGA using the chip main clock. Deserializes a 5-bit programming frame into the amplifier gain registers.
- Raises the ready flag back to the FPGA once the gain registers are loaded.
- Drives the gain controls of amplifiers A1/A2 for the rest of the chip.

Parameters:
- NBITS, 5, frame length in bits: 3 bits for A1 gain, then 2 bits for A2 gain.
- GAINA1_RST, 0, reset/default value of o_gainA1 (range 0-7).
- GAINA2_RST, 0, reset/default value of o_gainA2 (range 0-3).
- TIMEOUT, 255, main-clock cycles with no sclk rising edge mid-frame before the frame is aborted (optional feature only).

Ports:
- i_mainclk  input  1  chip main clock; all logic is on its rising edge.
- i_resetAll  input  1  synchronous, active-high reset.
- i_sclk  input  1  serial clock from FPGA; asynchronous to i_mainclk, idles high.
- i_sdin  input  1  serial data from FPGA; changes on sclk falling edge.
- o_gainA1  output  3  A1 gain code.
- o_gainA2  output  2  A2 gain code.
- o_ready  output  1  high once a full frame is loaded (to FPGA i_ready).
- o_abort  output  1  one-cycle pulse when a frame is aborted (0 when feature is compiled out).

Behaviour:
- One clock (i_mainclk). Reset is synchronous and active-high (i_resetAll).
- Reset values:
  - o_gainA1=GAINA1_RST, o_gainA2=GAINA2_RST, o_ready=0, o_abort=0.
  - Shift register=0, bit counter=0, state=sWAIT.
  - Synchronizer flops and previous-sclk flop reset to 1, so no false edge is seen after reset.
- Input sync: i_sclk and i_sdin each pass through 2-flop synchronizers.
- Edge detect: sclk_rise = sync_sclk & ~sclk_prev. Falling edges are ignored.
- Sampling: on sclk_rise, sync_sdin shifts in at the LSB (shreg <= {shreg[NBITS-2:0], sync_sdin}). Bits arrive MSB first, giving the frame {A1[2],A1[1],A1[0],A2[1],A2[0]}.
- Latency: a raw i_sclk rising edge is sampled 3 i_mainclk cycles later (2 sync flops + edge register).
- FSM states: sWAIT, sSHIFT, sDONE.
  - sWAIT: first sclk_rise shifts bit 0, sets bitcnt=1, and moves to sSHIFT.
  - sSHIFT: each sclk_rise shifts and increments bitcnt.
  - When the NBITS-th bit is shifted (bitcnt reaches NBITS on that cycle), go to sDONE on the next cycle.
  - Entering sDONE loads o_gainA1=shreg[4:2] and o_gainA2=shreg[1:0] and sets o_ready=1, all in the same cycle. o_ready rises 1 cycle after the final sample.
  - sDONE: sticky. Further sclk edges are ignored; gains and o_ready hold until i_resetAll.
- Gain outputs change only on entry to sDONE. A partial frame never alters them.
- Bit counter width is clog2(NBITS+1) and it never wraps; the counter stops at NBITS.
- Reset mid-frame: the next cycle returns to the reset values, and any partial frame is discarded.
- Reset asserted on the same cycle as sclk_rise: reset wins and the bit is not captured.
- sclk held high forever: the FSM stays in sWAIT and o_ready stays 0.

Optional Feature:
- Macro: PROG_TIMEOUT_EN.
- Defined:
  - An idle counter runs in sSHIFT only. It clears on each sclk_rise and increments otherwise.
  - When the counter reaches TIMEOUT: return to sWAIT, clear shreg and bitcnt, pulse o_abort for 1 cycle. Gains are unchanged and o_ready stays 0.
  - The counter saturates and is held at 0 outside sSHIFT.
- Undefined: no idle counter. o_abort is tied to 0, and sSHIFT waits indefinitely for the remaining edges.

Test Plan:
- Reset, then send FPGA frame gainA1=6, gainA2=1 (bits 1,1,0,0,1) with sclk period 32 mainclk cycles -> o_gainA1=3'd6, o_gainA2=2'd1, o_ready rises 4 cycles after the 5th raw sclk rise.
- After o_ready=1, send 5 more sclk pulses with bits 0,0,0,0,0 -> gains remain 6/1 and o_ready stays 1.
- Send 3 bits (1,0,1), then assert i_resetAll for 1 cycle; then send full frame 0,1,1,1,0 -> o_gainA1=3, o_gainA2=2, o_ready=1; no output changes before the 5th bit.
- Toggle i_sdin while sclk stays high for 100 cycles, then send nothing -> o_ready=0 and gains stay at GAINA1_RST/GAINA2_RST.
- (PROG_TIMEOUT_EN, TIMEOUT=255) Send 2 bits, then stall sclk high -> o_abort pulses exactly once, 255 cycles after the last sclk_rise. Then full frame 1,0,1,1,1 -> o_gainA1=5, o_gainA2=3, o_ready=1.
- Assert i_resetAll on the same cycle as the detected 5th sclk_rise -> o_ready=0, gains reset, FSM in sWAIT.
